// File: rtl/immgen_pipe.sv
// immgen_pipe: registered immediate generator for the decode stage.
// Classifies a 32-bit instruction's immediate format, extends the immediate
// to XLEN and passes it out through a 2-entry (main + skid) buffer so the
// upstream ready never depends combinationally on the downstream ready.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready   input handshake
//   i_instr, i_tag      instruction word and pass-through sideband
//   o_valid / i_ready   output handshake
//   o_imm, o_fmt        extended immediate and format code (0 R .. 6 Z, 7 none)
//   o_illegal, o_tag    unrecognised instruction flag and its tag
module immgen_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter bit          ZIMM_EN = 1'b1,
  parameter int unsigned TAG_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fmt,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t RST_ENTRY = '{imm: '0, fmt: FMT_NONE, ill: 1'b0, tag: '0};

  logic [6:0]      w_opc;
  logic [31:0]     w_imm32;
  logic            w_sext;
  logic [2:0]      w_fmt;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;
  entry_t          w_in;

  entry_t r_main;
  entry_t r_skid;
  logic   r_main_valid;
  logic   r_skid_valid;
  logic   r_ready;

  logic w_accept;
  logic w_drain;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;
  logic w_main_ld_skid;
  logic w_main_ld_in;
  logic w_skid_ld_in;

  assign w_opc = i_instr[6:0];

  // Immediate decode; w_imm32 is already 32-bit sign-extended where needed
  always_comb begin
    w_fmt   = FMT_NONE;
    w_ill   = 1'b1;
    w_imm32 = '0;
    w_sext  = 1'b0;
    if (i_instr[1:0] == 2'b11) begin
      w_ill = 1'b0;
      case (w_opc)
        7'h33: w_fmt = FMT_R;
        7'h13, 7'h03, 7'h67, 7'h0F: begin
          w_fmt   = FMT_I;
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
          w_sext  = 1'b1;
        end
        7'h23: begin
          w_fmt   = FMT_S;
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
          w_sext  = 1'b1;
        end
        7'h63: begin
          w_fmt   = FMT_B;
          w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
          w_sext  = 1'b1;
        end
        7'h6F: begin
          w_fmt   = FMT_J;
          w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};
          w_sext  = 1'b1;
        end
        7'h37, 7'h17: begin
          w_fmt   = FMT_U;
          w_imm32 = {i_instr[31:12], 12'b0};
          w_sext  = 1'b1;
        end
        7'h73: begin
          if (ZIMM_EN && i_instr[14]) begin
            w_fmt   = FMT_Z;
            w_imm32 = {27'b0, i_instr[19:15]};
          end else begin
            w_fmt   = FMT_I;
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            w_sext  = 1'b1;
          end
        end
        default: begin
          w_fmt = FMT_NONE;
          w_ill = 1'b1;
        end
      endcase
    end
    // Widening to XLEN: sign from bit 31 (RV64 U included), zero for Z/R/none
    if (w_sext) w_imm = XLEN'($signed(w_imm32));
    else        w_imm = XLEN'(w_imm32);
  end

  always_comb begin
    w_in = '{imm: w_imm, fmt: w_fmt, ill: w_ill, tag: i_tag};
  end

  assign w_accept = i_valid && r_ready;
  assign w_drain  = r_main_valid && i_ready;

  // Main/skid steering: the skid always has priority into a free main slot
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_ld_skid   = 1'b0;
    w_main_ld_in     = 1'b0;
    w_skid_ld_in     = 1'b0;
    if (!r_main_valid || w_drain) begin
      if (r_skid_valid) begin
        w_main_ld_skid   = 1'b1;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = w_accept;
        w_skid_ld_in     = w_accept;
      end else if (w_accept) begin
        w_main_ld_in     = 1'b1;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_ld_in     = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Storage; ready is its own flop so it never sees i_ready combinationally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_main       <= RST_ENTRY;
      r_skid       <= RST_ENTRY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_ready      <= !w_skid_valid_nxt;
      if (w_main_ld_skid)    r_main <= r_skid;
      else if (w_main_ld_in) r_main <= w_in;
      if (w_skid_ld_in)      r_skid <= w_in;
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = r_main_valid;
  assign o_imm     = r_main.imm;
  assign o_fmt     = r_main.fmt;
  assign o_illegal = r_main.ill;
  assign o_tag     = r_main.tag;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: two instances (XLEN=32/ZIMM on, XLEN=64/ZIMM off)
// share one stimulus stream and are checked every cycle against a queue model.
module tb_immgen_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_instr;
  logic [31:0] i_tag;

  logic        a_ready, a_valid, a_ill;
  logic [31:0] a_imm, a_tag;
  logic [2:0]  a_fmt;
  logic        b_ready, b_valid, b_ill;
  logic [63:0] b_imm;
  logic [31:0] b_tag;
  logic [2:0]  b_fmt;

  int n_checks = 0;
  int n_errors = 0;
  int drv_acc  = 0;

  logic [31:0] q_ins[$];
  logic [31:0] q_tag[$];
  logic [31:0] s_ins [0:26];

  always #5 i_clk = ~i_clk;

  immgen_pipe #(.XLEN(32), .ZIMM_EN(1'b1), .TAG_W(32)) u_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(a_ready),
    .i_instr(i_instr), .i_tag(i_tag), .o_valid(a_valid), .i_ready(i_ready),
    .o_imm(a_imm), .o_fmt(a_fmt), .o_illegal(a_ill), .o_tag(a_tag));

  immgen_pipe #(.XLEN(64), .ZIMM_EN(1'b0), .TAG_W(32)) u_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(b_ready),
    .i_instr(i_instr), .i_tag(i_tag), .o_valid(b_valid), .i_ready(i_ready),
    .o_imm(b_imm), .o_fmt(b_fmt), .o_illegal(b_ill), .o_tag(b_tag));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the format rules, using signed 64-bit arithmetic
  function automatic void mdec(input logic [31:0] ins, input bit zen,
                               output logic [63:0] imm, output logic [2:0] fmt,
                               output logic ill);
    longint s;
    s   = longint'($signed(ins));
    imm = 64'd0;
    fmt = 3'd7;
    ill = 1'b1;
    if (ins[1:0] == 2'b11) begin
      ill = 1'b0;
      case (ins[6:0])
        7'h33: fmt = 3'd0;
        7'h13, 7'h03, 7'h67, 7'h0F: begin fmt = 3'd1; imm = s >>> 20; end
        7'h23: begin
          fmt = 3'd2;
          imm = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
        end
        7'h63: begin
          fmt = 3'd3;
          imm = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
        end
        7'h6F: begin
          fmt = 3'd5;
          imm = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
        end
        7'h37, 7'h17: begin fmt = 3'd4; imm = (s >>> 12) <<< 12; end
        7'h73: begin
          if (zen && ins[14]) begin fmt = 3'd6; imm = longint'(ins[19:15]); end
          else begin fmt = 3'd1; imm = s >>> 20; end
        end
        default: begin ill = 1'b1; fmt = 3'd7; end
      endcase
    end
  endfunction

  task automatic chk_reset_outs(input string where);
    chk({where, " a_valid"}, 64'(a_valid), 64'd0);
    chk({where, " a_ready"}, 64'(a_ready), 64'd1);
    chk({where, " a_imm"},   64'(a_imm),   64'd0);
    chk({where, " a_fmt"},   64'(a_fmt),   64'd7);
    chk({where, " a_ill"},   64'(a_ill),   64'd0);
    chk({where, " a_tag"},   64'(a_tag),   64'd0);
    chk({where, " b_valid"}, 64'(b_valid), 64'd0);
    chk({where, " b_ready"}, 64'(b_ready), 64'd1);
    chk({where, " b_imm"},   b_imm,        64'd0);
    chk({where, " b_fmt"},   64'(b_fmt),   64'd7);
  endtask

  // Compare process: the model holds accepted entries in order; ready means
  // fewer than two are held, valid means at least one is.
  always begin
    logic        exp_ready, exp_valid, acc, drn, ill;
    logic [63:0] imm;
    logic [2:0]  fmt;
    @(negedge i_clk);
    if (i_rst) begin
      chk_reset_outs("in_reset");
      q_ins.delete();
      q_tag.delete();
    end else begin
      exp_ready = (q_ins.size() < 2);
      exp_valid = (q_ins.size() > 0);
      chk("a_ready", 64'(a_ready), 64'(exp_ready));
      chk("a_valid", 64'(a_valid), 64'(exp_valid));
      chk("b_ready", 64'(b_ready), 64'(exp_ready));
      chk("b_valid", 64'(b_valid), 64'(exp_valid));
      if (exp_valid) begin
        mdec(q_ins[0], 1'b1, imm, fmt, ill);
        chk("a_imm", 64'(a_imm), {32'd0, imm[31:0]});
        chk("a_fmt", 64'(a_fmt), 64'(fmt));
        chk("a_ill", 64'(a_ill), 64'(ill));
        chk("a_tag", 64'(a_tag), 64'(q_tag[0]));
        mdec(q_ins[0], 1'b0, imm, fmt, ill);
        chk("b_imm", b_imm, imm);
        chk("b_fmt", 64'(b_fmt), 64'(fmt));
        chk("b_ill", 64'(b_ill), 64'(ill));
        chk("b_tag", 64'(b_tag), 64'(q_tag[0]));
      end
      acc = i_valid && exp_ready;
      drn = exp_valid && i_ready;
      @(posedge i_clk);
      if (!i_rst) begin
        if (drn) begin void'(q_ins.pop_front()); void'(q_tag.pop_front()); end
        if (acc) begin q_ins.push_back(i_instr); q_tag.push_back(i_tag); end
      end
    end
  end

  // Presents s_ins[first..] one after another, advancing on observed accept.
  // Entered and left at 1 time unit after a rising edge.
  task automatic feed(input int first, input int cnt);
    for (int k = first; k < first + cnt; k++) begin
      bit done;
      int guard;
      done    = 1'b0;
      guard   = 0;
      i_valid = 1'b1;
      i_instr = s_ins[k];
      i_tag   = 32'hA000_0000 + 32'(k);
      while (!done) begin
        @(negedge i_clk);
        done = a_ready;
        @(posedge i_clk);
        #1;
        guard++;
        if (!done && guard > 50) begin
          chk("accept_timeout", 64'd0, 64'd1);
          break;
        end
      end
      if (done) drv_acc++;
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    int          base;

    s_ins = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h800002B7, 32'h00000033,
              32'h300FD073, 32'h00000000, 32'h00004501, 32'hFFDFF06F, 32'h12345017,
              32'h0000000F, 32'h8000A067, 32'hFFC42183, 32'h0000007F,
              32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213,
              32'h12300513, 32'h45600593, 32'h80000537,
              32'hFE000EE3, 32'h300FD073, 32'h00004501, 32'hFFF00093, 32'h00112623,
              32'h800002B7};

    // Model pinned to hand-computed values
    mdec(32'hFFF00093, 1'b1, imm, fmt, ill);
    chk("pin addi imm", imm, 64'hFFFF_FFFF_FFFF_FFFF); chk("pin addi fmt", 64'(fmt), 64'd1);
    mdec(32'h00112623, 1'b1, imm, fmt, ill);
    chk("pin sw imm", imm, 64'h0000_0000_0000_000C); chk("pin sw fmt", 64'(fmt), 64'd2);
    mdec(32'hFE000EE3, 1'b1, imm, fmt, ill);
    chk("pin beq imm", imm, 64'hFFFF_FFFF_FFFF_FFFC); chk("pin beq fmt", 64'(fmt), 64'd3);
    mdec(32'h800002B7, 1'b1, imm, fmt, ill);
    chk("pin lui imm", imm, 64'hFFFF_FFFF_8000_0000); chk("pin lui fmt", 64'(fmt), 64'd4);
    mdec(32'h300FD073, 1'b1, imm, fmt, ill);
    chk("pin csri z imm", imm, 64'h1F); chk("pin csri z fmt", 64'(fmt), 64'd6);
    mdec(32'h300FD073, 1'b0, imm, fmt, ill);
    chk("pin csri i imm", imm, 64'h300); chk("pin csri i fmt", 64'(fmt), 64'd1);
    mdec(32'h00004501, 1'b1, imm, fmt, ill);
    chk("pin c.op ill", 64'(ill), 64'd1); chk("pin c.op fmt", 64'(fmt), 64'd7);

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_instr = '0;
    i_tag   = '0;
    #1;
    chk_reset_outs("power_on");
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Streaming, full throughput
    feed(0, 14);
    repeat (3) @(posedge i_clk);
    #1;

    // Back-pressure: i_ready low for 3 edges while 4 instructions are offered
    base = drv_acc;
    fork
      feed(14, 4);
      begin
        i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("bp accepted", 64'(drv_acc - base), 64'd2);
        chk("bp a_ready low", 64'(a_ready), 64'd0);
        chk("bp head tag", 64'(a_tag), 64'hA000_000E);
        i_ready = 1'b1;
      end
    join
    repeat (4) @(posedge i_clk);
    #1;

    // Asynchronous reset with main and skid both full
    i_ready = 1'b0;
    feed(18, 2);
    chk("pre-rst a_ready", 64'(a_ready), 64'd0);
    #2;
    i_rst = 1'b1;
    #1;
    chk_reset_outs("async_rst");
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    feed(20, 1);
    chk("post-rst valid", 64'(a_valid), 64'd1);
    chk("post-rst tag", 64'(a_tag), 64'hA000_0014);
    chk("post-rst b_imm", b_imm, 64'hFFFF_FFFF_8000_0000);

    // Mixed stall pattern
    fork
      feed(21, 6);
      begin
        for (int c = 0; c < 16; c++) begin
          i_ready = (c % 3) != 0;
          @(posedge i_clk);
          #1;
        end
        i_ready = 1'b1;
      end
    join
    repeat (6) @(posedge i_clk);
    #1;
    chk("drained a_valid", 64'(a_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

Registered, parametrised immediate generator for the decode stage. It accepts one 32-bit instruction per cycle through a valid/ready handshake and classifies its immediate format. It outputs the immediate sign- or zero-extended to XLEN, plus a format code, an illegal flag and a pass-through tag (normally the PC). A 2-entry skid buffer gives full throughput under back-pressure, so decode can stall without a combinational ready path from execute.

## Interface
- XLEN, 32: immediate output width; legal values 32 or 64.
- ZIMM_EN, 1: 1 = SYSTEM funct3[2]=1 (CSRxxI) yields zero-extended 5-bit zimm; 0 = treated as I-type.
- TAG_W, 32: width of pass-through tag.

- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input instruction valid.
- o_ready  out  1  block can accept an input this cycle.
- i_instr  in  32  instruction word.
- i_tag  in  TAG_W  sideband carried with the instruction.
- o_valid  out  1  output holds a result.
- i_ready  in  1  consumer accepts the output this cycle.
- o_imm  out  XLEN  immediate.
- o_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (csr zimm), 7 none.
- o_illegal  out  1  opcode not recognised, or instr[1:0]≠2'b11.
- o_tag  out  TAG_W  tag of the instruction on the output.

## Operation
- Decode is combinational on i_instr. Its result is captured on accept (i_valid && o_ready).
- Opcode → format:
  - 0x33 → R, imm 0.
  - 0x13, 0x03, 0x67, 0x0F → I.
  - 0x23 → S.
  - 0x63 → B.
  - 0x6F → J.
  - 0x37, 0x17 → U.
  - 0x73 → Z if ZIMM_EN and funct3[2]; otherwise I.
- Immediate bit fields:
  - I = instr[31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - J = {[31],[19:12],[20],[30:21],0}.
  - U = {[31:12],12'b0}.
  - Z = instr[19:15], zero-extended.
- Extension: every format except Z and R is sign-extended from instr[31] to XLEN. With XLEN=64, U is also sign-extended from bit 31 (RV64 semantics).
- Any other opcode, or instr[1:0]≠11: fmt 7, imm 0, illegal 1. Illegal entries still flow through the pipe; they are never dropped.
- Storage is a main register (drives the outputs) plus a skid register. The main-register update rule, evaluated per cycle, is:
  - Main empty, or main drained this cycle (o_valid && i_ready): main loads the skid entry if the skid is valid; otherwise it loads the accepted input, if any.
  - Main full and not draining, and an input is accepted: the input goes to the skid.
  - When the skid moves to main and an input is accepted in the same cycle, the input goes to the skid.
- o_ready = !skid_valid, driven from a register, with no combinational path from i_ready.
- Ordering is strict FIFO; no loss, no duplication.

## Timing
- Latency: accept at edge N → o_valid with result from edge N (visible in cycle N+1).
- Throughput: 1 instruction per cycle while i_ready is held high; the skid stays empty.
- Back-pressure: at most 2 instructions are held. o_ready falls the cycle after the skid fills and rises the cycle after the skid empties.
- Reset (async, any time, including mid-transfer): all entries are discarded.
  - o_valid=0, o_ready=1, o_imm=0, o_fmt=7, o_illegal=0, o_tag=0.
  - Outputs take these values immediately on assertion and hold them until the first edge after deassertion.
- o_imm, o_fmt, o_illegal and o_tag are stable whenever o_valid=1 && i_ready=0.

## Test plan
- Formats, XLEN=32, recorded as instruction → imm / fmt:
  - 0xFFF00093 (addi -1) → 0xFFFFFFFF / 1.
  - 0x00112623 (sw 12) → 0x0000000C / 2.
  - 0xFE000EE3 (beq -4) → 0xFFFFFFFC / 3.
  - 0x800002B7 (lui) → 0x80000000 / 4.
  - 0x33 R-type → 0 / 0.
- XLEN=64: 0x800002B7 → 0xFFFFFFFF80000000; 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
- CSR immediate 0x300FD073: ZIMM_EN=1 → imm 0x1F, fmt 6; ZIMM_EN=0 → imm 0x300, fmt 1.
- Illegal: 0x00000000 and 0x00004501 → fmt 7, illegal 1, imm 0, o_valid still asserted.
- Back-pressure: drive 4 back-to-back instructions with i_ready low for 3 cycles.
  - Exactly 2 are accepted; o_ready=0 from the cycle after the 2nd accept.
  - Raise i_ready: one output per cycle, in order, with matching tags; o_ready returns 1 the cycle after the skid drains.
  - The remaining 2 are then accepted and delivered.
- Reset: assert i_rst asynchronously while main and skid are both full.
  - All outputs take their reset values before the next edge.
  - After release, a new instruction appears 1 cycle after accept with no stale entries.
